sort4_seq_ctrl: RTL
===================

// Module: sort4_seq_ctrl
// PURPOSE
//  Time-multiplexed controller for the 4-entry compare-exchange sort network.
//  Accepts four WIDTH-bit values serially over a valid/ready port and holds them in a slot file.
//  Sequences the six compare-exchange steps through ONE shared comparator, one step per cycle.
//  Presents the sorted result in parallel under a valid/ready handshake.
//  Sits between a switch/serial source and the LED/display stage.
// PARAMETERS
//  WIDTH   2   bit width of each element (unsigned compare)
// PORTS
//  clk        in   1      system clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_data holds a value to load
//  in_ready   out  1      controller accepts a value this cycle
//  in_data    in   WIDTH  element to load
//  out_valid  out  1      out_d0..out_d3 hold a sorted result
//  out_ready  in   1      consumer takes the result this cycle
//  out_d0     out  WIDTH  slot0 (largest by default)
//  out_d1     out  WIDTH  slot1
//  out_d2     out  WIDTH  slot2
//  out_d3     out  WIDTH  slot3 (smallest by default)
//  busy       out  1      high while in SORT state
//  step       out  3      current compare step index, 0..5
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
//  - States: LOAD, SORT, DONE.
//  - Reset: state=LOAD, load count=0, step=0, slots 0..3=0, out_valid=0, busy=0.
//  - in_ready is decoded from state; it is 0 in any cycle where rst=1.
//  - LOAD:
//    - in_ready=1.
//    - On in_valid&in_ready: slot[cnt]<=in_data, cnt<=cnt+1.
//    - When the 4th value is accepted (cnt==3): state<=SORT, step<=0, cnt<=0.
//    - in_valid=0 holds cnt. Gaps between inputs are legal.
//  - SORT:
//    - in_ready=0, busy=1.
//    - Each cycle performs pair[step]; step<=step+1.
//    - Pair order by step: 0:(0,1) 1:(0,2) 2:(0,3) 3:(1,2) 4:(1,3) 5:(2,3).
//    - Swap rule (default descending): if slot[a] <= slot[b], exchange slot[a] and slot[b].
//      Swapping on equal is permitted; the result is identical.
//    - After step 5 executes: state<=DONE, step<=0.
//  - DONE:
//    - out_valid=1, in_ready=0.
//    - Slots and out_d* are held stable while out_ready=0.
//    - On out_ready=1: state<=LOAD, out_valid<=0 next cycle.
//    - in_valid is ignored in DONE, so no load/unload overlap.
//  - Outputs:
//    - out_d* always drive slot registers; they are meaningful only when out_valid=1.
//    - out_valid is registered.
//  - Latency: out_valid rises exactly 6 clocks after the edge that captured the 4th input.
//    Throughput is 1 result per (4 + 6 + 1) cycles minimum.
//  - Arithmetic: unsigned WIDTH-bit compare; no widening. cnt wraps 3->0 only via the SORT transition.
//  - Reset mid-operation (any state): abort, return to reset values next edge; partial data is discarded.
//  - rst has priority over every handshake in the same cycle.
// CONFIGURATION
//  - SORT4_ASCEND_EN undefined (default): descending order, swap when slot[a] <= slot[b].
//  - SORT4_ASCEND_EN defined: ascending order, swap when slot[a] >= slot[b];
//    out_d0 is smallest. Timing and handshakes are unchanged.
// TESTING
//  1. W=2, load 1,3,0,2 back-to-back -> out_d0..3 = 3,2,1,0;
//     out_valid 6 clocks after 4th capture; step walks 0..5 with busy=1.
//  2. Load 2,2,1,2 -> 2,2,2,1.
//     Load 0,0,0,0 -> all 0, still 6 SORT cycles.
//  3. Load 3,0,1,2 with in_valid low 2 cycles between each value
//     -> cnt holds during gaps; result 3,2,1,0.
//  4. In DONE, hold out_ready=0 for 5 cycles with in_valid=1
//     -> outputs stable, in_ready=0, nothing loaded;
//     out_ready=1 -> LOAD next cycle, in_ready=1.
//  5. Assert rst at SORT step 3 -> next cycle state LOAD, slots 0, out_valid 0, busy 0;
//     reload 1,3,0,2 -> 3,2,1,0.
//  6. Build with SORT4_ASCEND_EN; load 1,3,0,2 -> 0,1,2,3, same latency.

Source files
------------

// File: rtl/sort4_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sort4_seq_ctrl                                                  |
// | Loads four values serially, sorts them with one shared compare-exchange  |
// | unit over six steps, then presents them in parallel. Optional macro:     |
// | SORT4_ASCEND_EN (ascending order instead of descending).                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sort4_seq_ctrl #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d0,
  output logic [WIDTH-1:0] out_d1,
  output logic [WIDTH-1:0] out_d2,
  output logic [WIDTH-1:0] out_d3,
  output logic             busy,
  output logic [2:0]       step
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;
  logic [2:0]       r_step;
  logic [WIDTH-1:0] r_slot [4];
  logic             r_out_valid;

  logic [1:0]       w_a;
  logic [1:0]       w_b;
  logic [WIDTH-1:0] w_va;
  logic [WIDTH-1:0] w_vb;
  logic             w_swap;
  logic             w_load;

  // Pair schedule of the 4-input compare-exchange network.
  always_comb begin
    w_a = 2'd0;
    w_b = 2'd1;
    case (r_step)
      3'd0: begin w_a = 2'd0; w_b = 2'd1; end
      3'd1: begin w_a = 2'd0; w_b = 2'd2; end
      3'd2: begin w_a = 2'd0; w_b = 2'd3; end
      3'd3: begin w_a = 2'd1; w_b = 2'd2; end
      3'd4: begin w_a = 2'd1; w_b = 2'd3; end
      3'd5: begin w_a = 2'd2; w_b = 2'd3; end
      default: begin w_a = 2'd0; w_b = 2'd1; end
    endcase
  end

  assign w_va = r_slot[w_a];
  assign w_vb = r_slot[w_b];

`ifdef SORT4_ASCEND_EN
  assign w_swap = (w_va >= w_vb);
`else
  assign w_swap = (w_va <= w_vb);
`endif

  assign in_ready  = (r_state == S_LOAD) && !rst;
  assign w_load    = in_valid && in_ready;
  assign busy      = (r_state == S_SORT);
  assign step      = r_step;
  assign out_valid = r_out_valid;
  assign out_d0    = r_slot[0];
  assign out_d1    = r_slot[1];
  assign out_d2    = r_slot[2];
  assign out_d3    = r_slot[3];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_load && (r_cnt == 2'd3)) w_state_nxt = S_SORT;
      S_SORT:  if (r_step == 3'd5) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_cnt       <= 2'd0;
      r_step      <= 3'd0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_LOAD: begin
          if (w_load) begin
            r_slot[r_cnt] <= in_data;
            r_cnt         <= r_cnt + 2'd1;
            r_step        <= 3'd0;
          end
        end
        S_SORT: begin
          if (w_swap) begin
            r_slot[w_a] <= w_vb;
            r_slot[w_b] <= w_va;
          end
          if (r_step == 3'd5) begin
            r_step      <= 3'd0;
            r_out_valid <= 1'b1;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
